xm_mem_interface: RTL
=====================

# xm_mem_interface

Memory-bus interface that sits directly downstream of the XM multi-cycle controller. It turns the controller's single-cycle memory request (enable, read/write, byte/word, address, write data) into a multi-cycle external bus transaction. It inserts programmed wait states, waits for bus ready, and returns `memBusy_o` to stall the controller, plus read data with a completion strobe. It also detects misaligned word accesses and bus timeouts.

## Interface
- `WORD`, 16, data width (fixed at 16; byte lanes are [7:0] and [15:8])
- `ADDR`, 16, byte-address width
- `WAIT_STATES`, 1, minimum cycles in ACCESS before ready is sampled (0–15)
- `TIMEOUT`, 255, max cycles in ACCESS after wait states expire before abort (1–255)

Ports:
- `clk_i`  in  1  clock; all logic on rising edge
- `arst_i`  in  1  reset, synchronous, active-high
- `memEn_i`  in  1  request strobe, sampled only in IDLE
- `memRW_i`  in  1  0 = read, 1 = write
- `byteOp_i`  in  1  1 = byte access, 0 = word access
- `adr_i`  in  ADDR  byte address
- `wrData_i`  in  WORD  write data; byte writes use [7:0]
- `memBusy_o`  out  1  high while a transaction is outstanding
- `rdData_o`  out  WORD  registered read data; held until next read completes
- `rdValid_o`  out  1  one-cycle pulse when a read completes
- `alignErr_o`  out  1  one-cycle pulse on a rejected misaligned word request
- `busErr_o`  out  1  one-cycle pulse on a timeout abort
- `busAdr_o`  out  ADDR  word-aligned address: {adr[ADDR-1:1], 0}
- `busWrData_o`  out  WORD  write data to memory
- `busRdData_i`  in  WORD  read data from memory; valid when `busReady_i` is high
- `busCs_o`  out  1  chip select
- `busWe_o`  out  1  write enable
- `busBe_o`  out  2  byte enables, [0] = low lane
- `busReady_i`  in  1  memory ready

## Operation
- States are IDLE and ACCESS.
- **IDLE**
  - `memBusy_o`=0 and `busCs_o`=0.
  - On `memEn_i`=1, latch `adr_i`, `wrData_i`, `memRW_i` and `byteOp_i`.
  - If `byteOp_i`=0 and `adr_i[0]`=1: pulse `alignErr_o` next cycle, issue no bus cycle, stay in IDLE.
  - Otherwise: load the wait counter with `WAIT_STATES`, load the timeout counter with `TIMEOUT`, go to ACCESS.
- **ACCESS**
  - Outputs: `memBusy_o`=1, `busCs_o`=1, `busWe_o`=latched RW, bus address/data/byte enables driven from the latched values. All bus outputs are stable for the whole state.
  - Wait counter: decrements each cycle while nonzero; `busReady_i` is ignored while it is nonzero.
  - Completion: when the wait counter is 0 and `busReady_i`=1:
    - read: capture `rdData_o` and pulse `rdValid_o` next cycle;
    - write: no pulse;
    - go to IDLE.
  - Timeout: when the wait counter is 0 and `busReady_i`=0, the timeout counter decrements. If it reaches 0, pulse `busErr_o`, leave `rdData_o` unchanged, go to IDLE.
- **Byte enables:** word access → 2'b11; byte access with `adr[0]`=0 → 2'b01; byte access with `adr[0]`=1 → 2'b10.
- **Byte write:** `busWrData_o` = {wrData[7:0], wrData[7:0]} (replicated on both lanes).
- **Byte read:** `rdData_o` = {8'h00, selected lane}, where the lane is chosen by the latched `adr[0]`. Zero-extended; the datapath performs any merge.
- **Word read:** `rdData_o` = `busRdData_i`.
- `memEn_i` asserted while in ACCESS is ignored. It is neither queued nor errored.
- Reset (any state): go to IDLE, clear both counters, all outputs 0 (including `rdData_o`, `busAdr_o`, `busWrData_o`, `busBe_o`). A reset in the middle of ACCESS aborts the transaction with no pulse.

## Timing
- Request accepted in cycle N (IDLE, `memEn_i`=1).
- `memBusy_o` and `busCs_o` rise in cycle N+1.
- Earliest completion edge is the end of cycle N+1+`WAIT_STATES`, provided `busReady_i`=1 then.
- In cycle N+2+`WAIT_STATES`: `memBusy_o`=0, `rdValid_o`=1 for a read, and a new request may be accepted.
- Every additional not-ready cycle adds exactly one cycle of latency.
- Timeout: abort at the end of cycle N+1+`WAIT_STATES`+`TIMEOUT`-1 if `busReady_i` was never high; `busErr_o` is high in the following cycle.
- `alignErr_o` is high in cycle N+1; `memBusy_o` stays 0.
- `rdValid_o`, `alignErr_o` and `busErr_o` are mutually exclusive and each lasts exactly one cycle.

## Test plan
- **Word read:** `WAIT_STATES`=1, `busReady_i`=1, read at 0x0010 with `busRdData_i`=0xBEEF → `busBe_o`=11 and `memBusy_o` high for 2 cycles; `rdValid_o` 3 cycles after request; `rdData_o`=0xBEEF.
- **Byte read, high lane:** read at 0x0011 with `busRdData_i`=0xA55A → `busAdr_o`=0x0010, `busBe_o`=10, `rdData_o`=0x00A5.
- **Byte write:** byte write at 0x0020 with `wrData_i`=0x1234 → `busWe_o`=1, `busBe_o`=01, `busWrData_o`=0x3434; no `rdValid_o`.
- **Misaligned word:** word read at 0x0003 → `alignErr_o` pulses 1 cycle; `busCs_o` never rises; `memBusy_o` stays 0.
- **Ready stall and timeout:** hold `busReady_i`=0 for 3 extra cycles → completion delayed by exactly 3. Repeat with `TIMEOUT`=4 and ready never asserted → `busErr_o` pulse; state returns to IDLE; `rdData_o` keeps its previous value.
- **Reset and back-to-back:** assert `arst_i` mid-ACCESS → next cycle all outputs 0, no pulses. Re-issue a request in the same cycle `rdValid_o` is high → accepted, `memBusy_o` high next cycle.

Source files
------------

// File: rtl/xm_mem_interface.sv
// xm_mem_interface: converts the XM controller's single-cycle memory request
// into a multi-cycle external bus transaction with programmed wait states,
// ready handshake, misaligned-word rejection and bus timeout abort.
module xm_mem_interface #(
    parameter int WORD        = 16,
    parameter int ADDR        = 16,
    parameter int WAIT_STATES = 1,
    parameter int TIMEOUT     = 255
) (
    input  logic            clk_i,
    input  logic            arst_i,
    input  logic            memEn_i,
    input  logic            memRW_i,
    input  logic            byteOp_i,
    input  logic [ADDR-1:0] adr_i,
    input  logic [WORD-1:0] wrData_i,
    output logic            memBusy_o,
    output logic [WORD-1:0] rdData_o,
    output logic            rdValid_o,
    output logic            alignErr_o,
    output logic            busErr_o,
    output logic [ADDR-1:0] busAdr_o,
    output logic [WORD-1:0] busWrData_o,
    input  logic [WORD-1:0] busRdData_i,
    output logic            busCs_o,
    output logic            busWe_o,
    output logic [1:0]      busBe_o,
    input  logic            busReady_i
);

    localparam int HALF = WORD / 2;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [3:0]      r_wait;
    logic [7:0]      r_tmo;
    logic [ADDR-1:0] r_adr;
    logic [WORD-1:0] r_wdata;
    logic            r_rw;
    logic            r_byte;
    logic [WORD-1:0] r_rdData;
    logic            r_rdValid;
    logic            r_alignErr;
    logic            r_busErr;

    logic            w_misalign;
    logic            w_done;
    logic            w_tmo_hit;
    logic [WORD-1:0] w_rd_fmt;

    // A word access to an odd byte address cannot be expressed on the bus
    assign w_misalign = !byteOp_i && adr_i[0];
    // Ready only counts once the programmed wait states have elapsed
    assign w_done     = (r_wait == 4'd0) && busReady_i;
    // Last allowed not-ready cycle: counter would hit zero on this edge
    assign w_tmo_hit  = (r_wait == 4'd0) && !busReady_i && (r_tmo == 8'd1);
    // Byte reads are zero-extended from the lane picked by the address LSB
    assign w_rd_fmt   = r_byte ? {{HALF{1'b0}}, (r_adr[0] ? busRdData_i[WORD-1:HALF]
                                                          : busRdData_i[HALF-1:0])}
                               : busRdData_i;

    // State register
    always_ff @(posedge clk_i) begin
        if (arst_i) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state: accept aligned requests in IDLE; leave ACCESS on ready or timeout
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (memEn_i && !w_misalign) w_next = S_ACCESS;
            S_ACCESS: if (w_done || w_tmo_hit)    w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Request latch, counters, read capture and one-cycle status pulses
    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            r_wait     <= '0;
            r_tmo      <= '0;
            r_adr      <= '0;
            r_wdata    <= '0;
            r_rw       <= 1'b0;
            r_byte     <= 1'b0;
            r_rdData   <= '0;
            r_rdValid  <= 1'b0;
            r_alignErr <= 1'b0;
            r_busErr   <= 1'b0;
        end else begin
            r_rdValid  <= 1'b0;
            r_alignErr <= 1'b0;
            r_busErr   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (memEn_i) begin
                        r_adr   <= adr_i;
                        r_wdata <= wrData_i;
                        r_rw    <= memRW_i;
                        r_byte  <= byteOp_i;
                        if (w_misalign) begin
                            r_alignErr <= 1'b1;
                        end else begin
                            r_wait <= 4'(WAIT_STATES);
                            r_tmo  <= 8'(TIMEOUT);
                        end
                    end
                end
                S_ACCESS: begin
                    if (r_wait != 4'd0) begin
                        r_wait <= r_wait - 4'd1;
                    end else if (busReady_i) begin
                        if (!r_rw) begin
                            r_rdData  <= w_rd_fmt;
                            r_rdValid <= 1'b1;
                        end
                    end else begin
                        r_tmo <= r_tmo - 8'd1;
                        if (r_tmo == 8'd1) r_busErr <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Bus control: asserted only in ACCESS, driven from the latched request
    always_comb begin
        memBusy_o = 1'b0;
        busCs_o   = 1'b0;
        busWe_o   = 1'b0;
        busBe_o   = 2'b00;
        if (r_state == S_ACCESS) begin
            memBusy_o = 1'b1;
            busCs_o   = 1'b1;
            busWe_o   = r_rw;
            if (!r_byte)       busBe_o = 2'b11;
            else if (r_adr[0]) busBe_o = 2'b10;
            else               busBe_o = 2'b01;
        end
    end

    assign busAdr_o    = {r_adr[ADDR-1:1], 1'b0};
    assign busWrData_o = r_byte ? {r_wdata[HALF-1:0], r_wdata[HALF-1:0]} : r_wdata;
    assign rdData_o    = r_rdData;
    assign rdValid_o   = r_rdValid;
    assign alignErr_o  = r_alignErr;
    assign busErr_o    = r_busErr;

endmodule
